// File: rtl/tetris_cmd_scheduler_pkg.sv
// Shared definitions for the Tetris command scheduler.
// Holds the action codes, the FSM state encoding and the default field width.
package tetris_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [7:0] ACT_SPAWN  = 8'd0;
  localparam logic [7:0] ACT_DOWN   = 8'd1;
  localparam logic [7:0] ACT_LEFT   = 8'd2;
  localparam logic [7:0] ACT_RIGHT  = 8'd3;
  localparam logic [7:0] ACT_ROTATE = 8'd4;

  typedef enum logic [1:0] {
    S_SPAWN = 2'd0,
    S_PLAY  = 2'd1,
    S_LOCK  = 2'd2,
    S_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/tetris_cmd_scheduler_if.sv
// Command-stream bundle between the scheduler and its environment.
// master is the scheduler side, slave is the botik/LCG/field-engine side.
interface tetris_cmd_scheduler_if
  import tetris_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0]   player_cmd;
  logic               player_valid;
  logic               player_ready;
  logic [WIDTH-1:0]   prng_data;
  logic               prng_enable;
  logic               is_touch;
  logic               is_lose;
  logic [2*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               game_over;

  modport master (
    input  player_cmd, player_valid, prng_data, is_touch, is_lose, out_ready,
    output player_ready, prng_enable, out_data, out_valid, game_over
  );

  modport slave (
    output player_cmd, player_valid, prng_data, is_touch, is_lose, out_ready,
    input  player_ready, prng_enable, out_data, out_valid, game_over
  );
endinterface

// File: rtl/tetris_cmd_scheduler_gravity_timer.sv
// Saturating gravity counter: counts while enabled, parks at PERIOD-1 with due
// raised until cleared.
module gravity_timer #(
  parameter int PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic due
);
  localparam logic [15:0] LAST = 16'(PERIOD - 1);

  logic [15:0] cnt_r;

  assign due = (cnt_r == LAST);

  // Counter: clear wins over counting; holds once it reaches the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (clr) begin
      cnt_r <= 16'd0;
    end else if (en && !due) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/tetris_cmd_scheduler.sv
// Arbitrates gravity ticks, player moves and figure spawns into a single
// registered {action, data} command slot feeding the field engine.
module tetris_cmd_scheduler
  import tetris_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int GRAVITY_PERIOD = 16,
  parameter int FIGURE_COUNT   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  tetris_cmd_scheduler_if.master bus
);
  localparam logic [WIDTH-1:0] FIG_CNT = WIDTH'(FIGURE_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1'b1);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [2*WIDTH-1:0] out_data_r;
  logic [2*WIDTH-1:0] load_word_s;
  logic [WIDTH-1:0]   figure_s;
  logic               out_valid_r;
  logic               game_over_r;
  logic               slot_free_s;
  logic               in_play_s;
  logic               player_ready_s;
  logic               player_take_s;
  logic               spawn_load_s;
  logic               grav_load_s;
  logic               player_load_s;
  logic               lock_done_s;
  logic               load_s;
  logic               grav_due_s;
  logic               grav_clr_s;
  logic               grav_en_s;

  gravity_timer #(.PERIOD(GRAVITY_PERIOD)) u_gravity (
    .clk (clk),
    .rst (rst),
    .en  (grav_en_s),
    .clr (grav_clr_s),
    .due (grav_due_s)
  );

  // Slot arbitration: spawn, then gravity, then player; touch/lose block loads.
  always_comb begin
    slot_free_s    = !out_valid_r || bus.out_ready;
    in_play_s      = (state_r == S_PLAY);
    player_ready_s = in_play_s && slot_free_s && !grav_due_s && !bus.is_touch;
    player_take_s  = player_ready_s && bus.player_valid;
    spawn_load_s   = (state_r == S_SPAWN) && slot_free_s && !bus.is_lose;
    grav_load_s    = in_play_s && slot_free_s && grav_due_s && !bus.is_touch && !bus.is_lose;
    // Codes outside DOWN..ROTATE are still consumed, just never loaded.
    player_load_s  = player_take_s && !bus.is_lose &&
                     (bus.player_cmd >= WIDTH'(ACT_DOWN)) &&
                     (bus.player_cmd <= WIDTH'(ACT_ROTATE));
    lock_done_s    = (state_r == S_LOCK) && !out_valid_r && !bus.is_lose;
    grav_clr_s     = grav_load_s || lock_done_s;
    grav_en_s      = in_play_s;
    load_s         = spawn_load_s || grav_load_s || player_load_s;
    figure_s       = bus.prng_data % FIG_CNT;
    if (spawn_load_s) begin
      load_word_s = {WIDTH'(ACT_SPAWN), figure_s};
    end else if (grav_load_s) begin
      load_word_s = {WIDTH'(ACT_DOWN), ONE};
    end else begin
      load_word_s = {bus.player_cmd, ONE};
    end
  end

  // Next-state logic; a loss overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.is_lose) begin
      state_nxt_s = S_OVER;
    end else begin
      case (state_r)
        S_SPAWN: state_nxt_s = spawn_load_s ? S_PLAY : S_SPAWN;
        S_PLAY:  state_nxt_s = bus.is_touch ? S_LOCK : S_PLAY;
        S_LOCK:  state_nxt_s = lock_done_s ? S_SPAWN : S_LOCK;
        S_OVER:  state_nxt_s = S_OVER;
        default: state_nxt_s = S_OVER;
      endcase
    end
  end

  // State and registered command slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_SPAWN;
      out_data_r  <= {WIDTH'(ACT_SPAWN), ONE};
      out_valid_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (bus.is_lose) begin
        out_valid_r <= 1'b0;
        game_over_r <= 1'b1;
      end else if (load_s) begin
        out_data_r  <= load_word_s;
        out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.out_data     = out_data_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.game_over    = game_over_r;
  assign bus.player_ready = player_ready_s;
  // The LCG advances on the same edge that captures the current figure.
  assign bus.prng_enable  = spawn_load_s && !rst;
endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Directed bench for tetris_cmd_scheduler with GRAVITY_PERIOD=4, FIGURE_COUNT=7.
module tb_tetris_cmd_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   pe_cnt = 0;

  tetris_cmd_scheduler_if #(.WIDTH(8)) bus ();

  tetris_cmd_scheduler #(
    .WIDTH(8),
    .GRAVITY_PERIOD(4),
    .FIGURE_COUNT(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.prng_enable === 1'b1) pe_cnt <= pe_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.player_cmd   = 8'd0;
    bus.player_valid = 1'b0;
    bus.prng_data    = 8'd9;
    bus.is_touch     = 1'b0;
    bus.is_lose      = 1'b0;
    bus.out_ready    = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_data", 32'(bus.out_data), 32'h0001);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pready", 32'(bus.player_ready), 32'd0);
    chk("rst_penable", 32'(bus.prng_enable), 32'd0);
    chk("rst_gover", 32'(bus.game_over), 32'd0);

    // First spawn: figure 9 % 7 = 2
    rst = 1'b0;
    #1;
    chk("spawn_penable", 32'(bus.prng_enable), 32'd1);
    step();  // E1
    chk("spawn_data", 32'(bus.out_data), 32'h0002);
    chk("spawn_valid", 32'(bus.out_valid), 32'd1);
    chk("spawn_penable_off", 32'(bus.prng_enable), 32'd0);

    // Idle play: DOWN visible after E5 and E9
    for (int k = 2; k <= 12; k++) begin
      step();
      chk($sformatf("idle_valid_e%0d", k), 32'(bus.out_valid), ((k == 5) || (k == 9)) ? 32'd1 : 32'd0);
      if ((k == 5) || (k == 9)) chk($sformatf("idle_data_e%0d", k), 32'(bus.out_data), 32'h0101);
    end
    chk("pe_once", 32'(pe_cnt), 32'd1);

    // LEFT presented as gravity_due rises
    bus.player_cmd   = 8'd2;
    bus.player_valid = 1'b1;
    #1;
    chk("left_blocked", 32'(bus.player_ready), 32'd0);
    step();  // E13
    chk("left_down_first", 32'(bus.out_data), 32'h0101);
    chk("left_pready", 32'(bus.player_ready), 32'd1);
    step();  // E14
    chk("left_data", 32'(bus.out_data), 32'h0201);
    chk("left_valid", 32'(bus.out_valid), 32'd1);

    // RIGHT pending while out_ready held low for 10 cycles
    bus.player_cmd = 8'd3;
    step();  // E15
    chk("right_data", 32'(bus.out_data), 32'h0301);
    bus.player_valid = 1'b0;
    bus.out_ready    = 1'b0;
    for (int k = 16; k <= 25; k++) begin
      step();
      chk($sformatf("stall_data_e%0d", k), 32'(bus.out_data), 32'h0301);
      chk($sformatf("stall_valid_e%0d", k), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();  // E26
    chk("stall_down", 32'(bus.out_data), 32'h0101);
    chk("stall_down_valid", 32'(bus.out_valid), 32'd1);
    step();  // E27
    chk("no_dup_e27", 32'(bus.out_valid), 32'd0);
    step();  // E28
    chk("no_dup_e28", 32'(bus.out_valid), 32'd0);
    step();  // E29
    chk("no_dup_e29", 32'(bus.out_valid), 32'd0);
    step();  // E30
    chk("next_down", 32'(bus.out_data), 32'h0101);
    chk("next_down_valid", 32'(bus.out_valid), 32'd1);

    // Touch with a pending command, then drain
    bus.out_ready = 1'b0;
    bus.is_touch  = 1'b1;
    #1;
    chk("touch_pready", 32'(bus.player_ready), 32'd0);
    step();  // E31
    bus.is_touch = 1'b0;
    chk("lock_hold_data", 32'(bus.out_data), 32'h0101);
    chk("lock_hold_valid", 32'(bus.out_valid), 32'd1);
    step();  // E32
    chk("lock_hold2", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();  // E33
    chk("lock_drained", 32'(bus.out_valid), 32'd0);
    bus.prng_data = 8'd20;
    step();  // E34
    chk("respawn_penable", 32'(bus.prng_enable), 32'd1);
    chk("respawn_wait", 32'(bus.out_valid), 32'd0);
    step();  // E35
    chk("respawn_data", 32'(bus.out_data), 32'h0006);
    chk("respawn_valid", 32'(bus.out_valid), 32'd1);
    for (int k = 36; k <= 38; k++) begin
      step();
      chk($sformatf("restart_idle_e%0d", k), 32'(bus.out_valid), 32'd0);
    end
    step();  // E39
    chk("restart_down", 32'(bus.out_data), 32'h0101);
    chk("restart_down_valid", 32'(bus.out_valid), 32'd1);
    chk("pe_twice", 32'(pe_cnt), 32'd2);

    // Touch and lose together with a pending command
    bus.out_ready = 1'b0;
    bus.is_touch  = 1'b1;
    bus.is_lose   = 1'b1;
    step();  // E40
    chk("lose_gover", 32'(bus.game_over), 32'd1);
    chk("lose_valid", 32'(bus.out_valid), 32'd0);
    bus.is_touch     = 1'b0;
    bus.is_lose      = 1'b0;
    bus.out_ready    = 1'b1;
    bus.player_cmd   = 8'd3;
    bus.player_valid = 1'b1;
    for (int k = 41; k <= 43; k++) begin
      step();
      chk($sformatf("over_valid_e%0d", k), 32'(bus.out_valid), 32'd0);
      chk($sformatf("over_gover_e%0d", k), 32'(bus.game_over), 32'd1);
      chk($sformatf("over_penable_e%0d", k), 32'(bus.prng_enable), 32'd0);
      chk($sformatf("over_pready_e%0d", k), 32'(bus.player_ready), 32'd0);
    end
    bus.player_valid = 1'b0;

    // Mid-game reset forces outputs immediately
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(bus.out_data), 32'h0001);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_gover", 32'(bus.game_over), 32'd0);
    step();
    rst = 1'b0;
    step();  // F1
    chk("f1_spawn", 32'(bus.out_data), 32'h0006);

    // Codes 5 and 0 are consumed and dropped; player DOWN keeps the counter
    bus.player_cmd   = 8'd5;
    bus.player_valid = 1'b1;
    #1;
    chk("drop5_pready", 32'(bus.player_ready), 32'd1);
    step();  // F2
    chk("drop5_valid", 32'(bus.out_valid), 32'd0);
    bus.player_cmd = 8'd0;
    #1;
    chk("drop0_pready", 32'(bus.player_ready), 32'd1);
    step();  // F3
    chk("drop0_valid", 32'(bus.out_valid), 32'd0);
    bus.player_cmd = 8'd1;
    step();  // F4
    chk("pdown_data", 32'(bus.out_data), 32'h0101);
    chk("pdown_valid", 32'(bus.out_valid), 32'd1);
    bus.player_valid = 1'b0;
    #1;
    chk("pdown_due", 32'(bus.player_ready), 32'd0);
    step();  // F5
    chk("grav_after_pdown", 32'(bus.out_valid), 32'd1);
    chk("grav_after_pdown_data", 32'(bus.out_data), 32'h0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tetris_cmd_scheduler.md
# tetris_cmd_scheduler

Sequences the command stream into the Tetris field engine. It arbitrates between the automatic gravity tick, player moves from `botik`, and new-figure spawns drawn from the LCG. It reacts to `is_touch` and `is_lose`, and presents one `{action, data}` word at a time on a valid/ready port. It replaces the hard-wired action register in `instructions` and sits between `botik`/`linear_congruential_generator` and the field datapath.

## Interface
Parameters:
- `WIDTH`, 8, width of the action field and of the data field.
- `GRAVITY_PERIOD`, 16, cycles between automatic DOWN commands; legal range is 2 to 65535.
- `FIGURE_COUNT`, 7, number of figure shapes; legal range is 1 to 255.

Ports (`clk` rising edge is the only clock; `rst` is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `player_cmd`  in  WIDTH  player action code
- `player_valid`  in  1  `player_cmd` is meaningful
- `player_ready`  out  1  the scheduler consumes `player_cmd` this cycle
- `prng_data`  in  WIDTH  current LCG output
- `prng_enable`  out  1  one-cycle pulse that advances the LCG
- `is_touch`  in  1  the falling figure has landed
- `is_lose`  in  1  the field has overflowed
- `out_data`  out  2*WIDTH  `{action, data}` command word
- `out_valid`  out  1  `out_data` holds a command
- `out_ready`  in  1  the field engine accepts `out_data`
- `game_over`  out  1  sticky loss flag

## Operation
- Action codes: SPAWN=0, DOWN=1, LEFT=2, RIGHT=3, ROTATE=4.
- Data field:
  - SPAWN carries `prng_data % FIGURE_COUNT`.
  - All other commands carry 1.
- FSM states:
  - S_SPAWN: when the output slot is free, load a SPAWN command and pulse `prng_enable` for one cycle. Go to S_PLAY.
  - S_PLAY:
    - The gravity counter increments every cycle. At `GRAVITY_PERIOD-1` it raises `gravity_due` and holds there (saturates) until a DOWN is loaded, then clears to 0.
    - Priority: `gravity_due` first, then the player.
    - `player_ready = S_PLAY && slot_free && !gravity_due && !is_touch`.
    - When a player command is consumed:
      - Codes 2 to 4 are loaded as-is.
      - Code 1 is loaded as a player DOWN and does not clear the gravity counter.
      - Codes 0 and 5 and above are consumed and dropped.
    - `is_touch` high: go to S_LOCK.
  - S_LOCK: wait until `out_valid` is 0 (the pending command has drained). Then clear the gravity counter and go to S_SPAWN.
  - S_OVER: `game_over` is 1, `out_valid` is 0, `player_ready` is 0. The block stays here until `rst`.
- `is_lose` sends the FSM to S_OVER from any state. It wins over `is_touch` and over any pending command.
- The output slot is free when `!out_valid || out_ready`. Reloading in the same cycle as an acceptance is allowed.

## Timing
- Reset values:
  - `out_data`=16'h0001 (action 0, data 1).
  - `out_valid`=0, `player_ready`=0, `prng_enable`=0, `game_over`=0.
  - State is S_SPAWN and the gravity counter is 0.
- The first SPAWN appears with `out_valid`=1 one cycle after `rst` deasserts.
- `out_data` and `out_valid` are registered.
  - A command loaded at edge N is visible after edge N.
  - It is held stable until the cycle where `out_valid && out_ready`.
- Back-to-back throughput is one command per cycle when `out_ready` is held at 1.
- The `prng_enable` pulse coincides with the cycle the SPAWN is loaded. The figure uses the `prng_data` value from before the advance.
- `is_touch` and `is_lose` are sampled at the rising edge.
  - `is_lose` clears `out_valid` at the next edge.
  - `is_lose` sets `game_over` at the next edge.
- Gravity DOWN spacing is exactly `GRAVITY_PERIOD` cycles when `out_ready`=1 and no touch occurs. When `out_ready`=0, the DOWN is delayed until the slot frees; DOWNs are never queued twice.
- `rst` asserted mid-game immediately forces all outputs to their reset values.

## Structure
- Shared package `tetris_pkg` holds:
  - the action-code localparams;
  - the FSM state enum;
  - the default `WIDTH`.
- Sub-module `gravity_timer` contains the saturating counter with a clear input and the `due` output.

## Test plan
- Reset release, with `prng_data`=9 and `out_ready`=1:
  - the first accepted word is 16'h0002 (SPAWN, figure 9%7=2);
  - `prng_enable` pulses once.
- Idle play with `GRAVITY_PERIOD`=4 and `out_ready`=1 → after the spawn, 16'h0101 is emitted every 4 cycles.
- Player LEFT (8'h02) presented on the same cycle `gravity_due` rises:
  - DOWN 16'h0101 is issued first;
  - LEFT 16'h0201 is issued on the next cycle;
  - `player_ready` stays low until the DOWN has been loaded.
- `out_ready` held at 0 for 10 cycles with a pending RIGHT: `out_data` stays 16'h0301 and no extra DOWN is lost or duplicated.
- `is_touch` pulse followed by `out_ready` → exactly one SPAWN follows after the pending command drains; the gravity counter restarts from 0.
- `is_touch` and `is_lose` high on the same cycle while a command is pending:
  - `game_over`=1 and `out_valid`=0 at the next edge;
  - no SPAWN is issued;
  - `rst` returns the outputs to 16'h0001 with `out_valid`=0.
